// File: rtl/udma_eth_rxdesc_pkg.sv
// -----------------------------------------------------------------------------
// udma_eth_rxdesc_pkg
// Shared constants for the uDMA Ethernet RX descriptor ring manager:
//   - config-bus word addresses and register regions,
//   - descriptor word bit positions (OWN / ERR),
//   - STATUS register bit positions and the DROP counter width,
//   - CFG register bit positions.
// -----------------------------------------------------------------------------
package udma_eth_rxdesc_pkg;

  // Register regions selected by addr[5:4]
  localparam logic [1:0] REG_SADDR = 2'b00;
  localparam logic [1:0] REG_DESC  = 2'b01;

  // Single-word registers
  localparam logic [5:0] ADDR_HEAD   = 6'h20;
  localparam logic [5:0] ADDR_CFG    = 6'h21;
  localparam logic [5:0] ADDR_IRQ_EN = 6'h22;
  localparam logic [5:0] ADDR_STATUS = 6'h23;

  // Descriptor word layout
  localparam int DESC_OWN_BIT = 31;
  localparam int DESC_ERR_BIT = 30;

  // CFG register layout
  localparam int CFG_EN_BIT  = 0;
  localparam int CFG_CLR_BIT = 1;

  // STATUS register layout
  localparam int STAT_DONE   = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_OVF    = 2;
  localparam int STAT_FERR   = 3;
  localparam int STAT_W      = 4;
  localparam int DROP_LSB    = 8;
  localparam int DROP_W      = 8;

endpackage

// File: rtl/udma_eth_rxdesc_ring.sv
// -----------------------------------------------------------------------------
// udma_eth_rxdesc_ring
// RX descriptor ring manager for the uDMA Ethernet channel. Holds NUM_DESC
// buffer slots (start address, OWN, ERR, LEN), advances a hardware head
// pointer on every accepted frame, and keeps sticky status plus an IRQ.
//
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   cfg_*                  uDMA config bus (combinational read, no wait states)
//   rx_startaddr_o         buffer address of the head slot
//   rx_ready_o             head slot is hardware-owned and the ring is enabled
//   frame_done_i/len/err   end-of-frame pulse with its length and error flag
//   rx_irq_o               level interrupt, |(STATUS[3:0] & IRQ_EN)
//
// The config address must be at least 6 bits wide; only addr[5:0] decodes.
// -----------------------------------------------------------------------------
module udma_eth_rxdesc_ring
  import udma_eth_rxdesc_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int NUM_DESC       = 8,
  parameter int ADDR_W         = 6
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [31:0]               cfg_data_i,
  input  logic [ADDR_W-1:0]         cfg_addr_i,
  input  logic                      cfg_valid_i,
  input  logic                      cfg_rwn_i,
  output logic [31:0]               cfg_data_o,
  output logic                      cfg_ready_o,
  output logic [L2_AWIDTH_NOAL-1:0] rx_startaddr_o,
  output logic                      rx_ready_o,
  input  logic                      frame_done_i,
  input  logic [TRANS_SIZE-1:0]     frame_len_i,
  input  logic                      frame_err_i,
  output logic                      rx_irq_o
);

  localparam int HEAD_W = $clog2(NUM_DESC);
  typedef logic [HEAD_W-1:0] head_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [L2_AWIDTH_NOAL-1:0] r_saddr [NUM_DESC];
  logic [NUM_DESC-1:0]       r_own;
  logic [NUM_DESC-1:0]       r_err;
  logic [TRANS_SIZE-1:0]     r_len   [NUM_DESC];
  head_t                     r_head;
  logic                      r_en;
  logic [STAT_W-1:0]         r_irq_en;
  logic [STAT_W-1:0]         r_status;
  logic [DROP_W-1:0]         r_drop;

  // ---------------------------------------------------------------------------
  // Config bus decode
  // ---------------------------------------------------------------------------
  logic [5:0]        w_addr;
  logic [1:0]        w_region;
  logic [3:0]        w_idx;
  logic              w_wr;
  logic              w_saddr_wr;
  logic              w_desc_wr;
  logic              w_cfg_wr;
  logic              w_irqen_wr;
  logic              w_stat_wr;
  logic              w_clr;
  logic [STAT_W-1:0] w_w1c;
  logic              w_drop_clr;
  logic              w_unused;

  assign w_addr     = cfg_addr_i[5:0];
  assign w_region   = w_addr[5:4];
  assign w_idx      = w_addr[3:0];
  assign w_wr       = cfg_valid_i & ~cfg_rwn_i;
  assign w_saddr_wr = w_wr & (w_region == REG_SADDR);
  assign w_desc_wr  = w_wr & (w_region == REG_DESC);
  assign w_cfg_wr   = w_wr & (w_addr == ADDR_CFG);
  assign w_irqen_wr = w_wr & (w_addr == ADDR_IRQ_EN);
  assign w_stat_wr  = w_wr & (w_addr == ADDR_STATUS);
  assign w_clr      = w_cfg_wr & cfg_data_i[CFG_CLR_BIT];
  assign w_w1c      = w_stat_wr ? cfg_data_i[STAT_W-1:0] : '0;
  assign w_drop_clr = w_w1c[STAT_OVF];
  assign w_unused   = ^cfg_data_i;

  // ---------------------------------------------------------------------------
  // Frame handling
  // ---------------------------------------------------------------------------
  logic              w_ready;
  logic              w_accept;
  logic              w_drop;
  head_t             w_head_nxt;
  logic              w_full;
  logic [STAT_W-1:0] w_stat_set;

  assign w_ready    = r_en & ~r_own[r_head];
  // CLR discards a coincident frame outright: neither accepted nor counted.
  assign w_accept   = frame_done_i &  w_ready & ~w_clr;
  assign w_drop     = frame_done_i & ~w_ready & ~w_clr;
  // NUM_DESC is a power of two, so the natural wrap of head_t is the modulo.
  assign w_head_nxt = head_t'(r_head + 1'b1);
  // FULL looks at the slot the head is about to land on, before this edge.
  assign w_full     = r_own[w_head_nxt];

  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it holding its old value (no latch).
    w_stat_set            = '0;
    w_stat_set[STAT_DONE] = w_accept;
    w_stat_set[STAT_FULL] = w_accept & w_full;
    w_stat_set[STAT_OVF]  = w_drop;
    w_stat_set[STAT_FERR] = w_accept & frame_err_i;
  end

  // ---------------------------------------------------------------------------
  // Buffer start addresses (survive CLR)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      // NOTE: the slot arrays are plain flops, not RAM, so every entry is
      // reset; software relies on reading zero after reset.
      for (int i = 0; i < NUM_DESC; i++) r_saddr[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_DESC; i++) begin
        if (w_saddr_wr && (w_idx == 4'(i))) r_saddr[i] <= cfg_data_i[L2_AWIDTH_NOAL-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Descriptor slots
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_own <= '0;
      r_err <= '0;
      for (int i = 0; i < NUM_DESC; i++) r_len[i] <= '0;
    end else if (w_clr) begin
      r_own <= '0;
      r_err <= '0;
      for (int i = 0; i < NUM_DESC; i++) r_len[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_DESC; i++) begin
        if (w_desc_wr && (w_idx == 4'(i))) r_own[i] <= cfg_data_i[DESC_OWN_BIT];
      end
      // NOTE: state is updated with non-blocking assignments; when two of them
      // hit the same slot in one edge the later one wins, which is how the
      // hardware completion overrides a coincident software OWN write.
      if (w_accept) begin
        r_own[r_head] <= 1'b1;
        r_err[r_head] <= frame_err_i;
        r_len[r_head] <= frame_len_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Head pointer, control and status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_head   <= '0;
      r_en     <= 1'b0;
      r_irq_en <= '0;
      r_status <= '0;
      r_drop   <= '0;
    end else begin
      // EN follows every CFG write, including the one that carries CLR.
      if (w_cfg_wr)   r_en     <= cfg_data_i[CFG_EN_BIT];
      if (w_irqen_wr) r_irq_en <= cfg_data_i[STAT_W-1:0];

      if (w_clr) begin
        r_head   <= '0;
        r_status <= '0;
        r_drop   <= '0;
      end else begin
        if (w_accept) r_head <= w_head_nxt;
        // Set after clear: a new event in the W1C cycle stays visible.
        r_status <= (r_status & ~w_w1c) | w_stat_set;
        if (w_drop_clr)                 r_drop <= w_drop ? DROP_W'(1) : '0;
        else if (w_drop && ~&r_drop)    r_drop <= r_drop + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    case (w_region)
      REG_SADDR: begin
        for (int i = 0; i < NUM_DESC; i++) begin
          if (w_idx == 4'(i)) w_rdata[L2_AWIDTH_NOAL-1:0] = r_saddr[i];
        end
      end
      REG_DESC: begin
        for (int i = 0; i < NUM_DESC; i++) begin
          if (w_idx == 4'(i)) begin
            w_rdata[DESC_OWN_BIT]     = r_own[i];
            w_rdata[DESC_ERR_BIT]     = r_err[i];
            w_rdata[TRANS_SIZE-1:0]   = r_len[i];
          end
        end
      end
      default: begin
        case (w_addr)
          ADDR_HEAD:   w_rdata[HEAD_W-1:0] = r_head;
          ADDR_CFG:    w_rdata[CFG_EN_BIT] = r_en;
          ADDR_IRQ_EN: w_rdata[STAT_W-1:0] = r_irq_en;
          ADDR_STATUS: begin
            w_rdata[STAT_W-1:0]                 = r_status;
            w_rdata[DROP_LSB+DROP_W-1:DROP_LSB] = r_drop;
          end
          default:     w_rdata = '0;
        endcase
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cfg_data_o     = w_rdata;
  assign cfg_ready_o    = 1'b1;
  assign rx_startaddr_o = r_saddr[r_head];
  assign rx_ready_o     = w_ready;
  assign rx_irq_o       = |(r_status & r_irq_en);

endmodule

// File: tb/tb_udma_eth_rxdesc_ring.sv
// -----------------------------------------------------------------------------
// tb_udma_eth_rxdesc_ring
// Directed scenarios followed by a randomized phase, all compared against a
// behavioural model of the ring kept in plain bench variables.
// -----------------------------------------------------------------------------
module tb_udma_eth_rxdesc_ring;

  localparam int N  = 8;
  localparam int TS = 16;
  localparam int AW = 12;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic [31:0]   cfg_data_i;
  logic [5:0]    cfg_addr_i;
  logic          cfg_valid_i;
  logic          cfg_rwn_i;
  logic [31:0]   cfg_data_o;
  logic          cfg_ready_o;
  logic [AW-1:0] rx_startaddr_o;
  logic          rx_ready_o;
  logic          frame_done_i;
  logic [TS-1:0] frame_len_i;
  logic          frame_err_i;
  logic          rx_irq_o;

  always #5 clk_i = ~clk_i;

  udma_eth_rxdesc_ring #(
    .L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS), .NUM_DESC(N), .ADDR_W(6)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .cfg_data_i(cfg_data_i), .cfg_addr_i(cfg_addr_i),
    .cfg_valid_i(cfg_valid_i), .cfg_rwn_i(cfg_rwn_i),
    .cfg_data_o(cfg_data_o), .cfg_ready_o(cfg_ready_o),
    .rx_startaddr_o(rx_startaddr_o), .rx_ready_o(rx_ready_o),
    .frame_done_i(frame_done_i), .frame_len_i(frame_len_i),
    .frame_err_i(frame_err_i), .rx_irq_o(rx_irq_o)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int m_saddr [N];
  bit m_own   [N];
  bit m_err   [N];
  int m_len   [N];
  int m_head, m_irq_en, m_status, m_drop;
  bit m_en;

  int total = 0;
  int bad   = 0;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_saddr[i] = 0; m_own[i] = 0; m_err[i] = 0; m_len[i] = 0;
    end
    m_head = 0; m_irq_en = 0; m_status = 0; m_drop = 0; m_en = 0;
  endfunction

  // One clock edge with the given inputs applied, evaluated on pre-edge state.
  function automatic void model_step(bit fd, int len, bit fe, bit wr, int addr, logic [31:0] data);
    bit ready, clr, full_pre;
    int nh, idx, region;
    ready    = m_en && !m_own[m_head];
    clr      = wr && (addr == 'h21) && data[1];
    nh       = (m_head + 1) % N;
    full_pre = m_own[nh];
    idx      = addr % 16;
    region   = addr / 16;
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        m_own[i] = 0; m_err[i] = 0; m_len[i] = 0;
      end
      m_head = 0; m_status = 0; m_drop = 0; m_en = data[0];
      return;
    end
    if (wr) begin
      if (region == 0 && idx < N)      m_saddr[idx] = int'(data) & 'hFFF;
      else if (region == 1 && idx < N) m_own[idx] = data[31];
      else if (addr == 'h21)           m_en = data[0];
      else if (addr == 'h22)           m_irq_en = int'(data) & 'hF;
      else if (addr == 'h23) begin
        m_status = m_status & ~(int'(data) & 'hF);
        if (data[2]) m_drop = 0;
      end
    end
    if (fd && ready) begin
      m_own[m_head] = 1;
      m_err[m_head] = fe;
      m_len[m_head] = len & 'hFFFF;
      m_status = m_status | 1;
      if (fe)       m_status = m_status | 8;
      if (full_pre) m_status = m_status | 2;
      m_head = nh;
    end else if (fd) begin
      m_status = m_status | 4;
      if (m_drop < 255) m_drop++;
    end
  endfunction

  function automatic logic [31:0] model_read(int addr);
    logic [31:0] v;
    int idx;
    v   = '0;
    idx = addr % 16;
    case (addr / 16)
      0: if (idx < N) v = 32'(m_saddr[idx]);
      1: if (idx < N) v = {m_own[idx], m_err[idx], 14'b0, 16'(m_len[idx])};
      default: begin
        case (addr)
          'h20: v = 32'(m_head);
          'h21: v = 32'(m_en);
          'h22: v = 32'(m_irq_en);
          'h23: v = 32'(m_status + m_drop * 256);
          default: v = '0;
        endcase
      end
    endcase
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Bench tasks
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit fd, input int len, input bit fe,
                      input bit wr, input int addr, input logic [31:0] data);
    @(negedge clk_i);
    frame_done_i = fd;
    frame_len_i  = TS'(len);
    frame_err_i  = fe;
    cfg_valid_i  = wr;
    cfg_rwn_i    = ~wr;
    cfg_addr_i   = 6'(addr);
    cfg_data_i   = data;
    @(posedge clk_i);
    model_step(fd, len, fe, wr, addr, data);
    #1;
    frame_done_i = 1'b0;
    cfg_valid_i  = 1'b0;
    cfg_rwn_i    = 1'b1;
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    step(1'b0, 0, 1'b0, 1'b1, addr, data);
  endtask

  task automatic frame(input int len, input bit fe);
    step(1'b1, len, fe, 1'b0, 0, '0);
  endtask

  task automatic rd(input int addr, input string tag);
    @(negedge clk_i);
    cfg_valid_i = 1'b1;
    cfg_rwn_i   = 1'b1;
    cfg_addr_i  = 6'(addr);
    #1;
    check($sformatf("%s@%02h", tag, addr), cfg_data_o, model_read(addr));
    cfg_valid_i = 1'b0;
  endtask

  // Read against a constant taken straight from the register description.
  task automatic rd_const(input int addr, input logic [31:0] exp, input string tag);
    @(negedge clk_i);
    cfg_valid_i = 1'b1;
    cfg_rwn_i   = 1'b1;
    cfg_addr_i  = 6'(addr);
    #1;
    check(tag, cfg_data_o, exp);
    cfg_valid_i = 1'b0;
  endtask

  task automatic chk_out(input string tag);
    check({tag, "_ready"}, 32'(rx_ready_o), 32'(m_en && !m_own[m_head]));
    check({tag, "_saddr"}, 32'(rx_startaddr_o), 32'(m_saddr[m_head]));
    check({tag, "_irq"},   32'(rx_irq_o), 32'((m_status & m_irq_en) != 0));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int          sel, a, h;
  bit          fd, wen;
  logic [31:0] d;

  initial begin
    rstn_i       = 1'b0;
    cfg_data_i   = '0;
    cfg_addr_i   = '0;
    cfg_valid_i  = 1'b0;
    cfg_rwn_i    = 1'b1;
    frame_done_i = 1'b0;
    frame_len_i  = '0;
    frame_err_i  = 1'b0;
    model_reset();
    #1;
    check("rst_ready", 32'(rx_ready_o), 32'd0);
    check("rst_saddr", 32'(rx_startaddr_o), 32'd0);
    check("rst_irq",   32'(rx_irq_o), 32'd0);
    check("rst_rdata", cfg_data_o, 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready_o), 32'd1);
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    rd_const('h23, 32'h0, "rst_status");
    rd_const('h20, 32'h0, "rst_head");

    // Program buffers and enable
    for (int i = 0; i < N; i++) wr(i, 32'(i * 'h100));
    wr('h21, 32'h1);
    check("en_ready", 32'(rx_ready_o), 32'd1);
    check("en_saddr", 32'(rx_startaddr_o), 32'h000);
    rd_const('h0A, 32'h0, "saddr_out_of_range");

    // Three frames, last with error
    wr('h22, 32'h8);
    frame(64, 1'b0);
    frame(128, 1'b0);
    frame(60, 1'b1);
    rd_const('h10, 32'h8000_0040, "desc0");
    rd_const('h11, 32'h8000_0080, "desc1");
    rd_const('h12, 32'hC000_003C, "desc2");
    rd_const('h20, 32'h3, "head3");
    rd_const('h23, 32'h9, "status9");
    check("irq_ferr", 32'(rx_irq_o), 32'd1);
    check("saddr_h3", 32'(rx_startaddr_o), 32'h300);
    wr('h22, 32'h2);
    check("irq_full_masked", 32'(rx_irq_o), 32'd0);

    // Fill the ring, then overflow twice
    for (int i = 0; i < 5; i++) frame(100 + i, 1'b0);
    rd_const('h23, 32'hB, "status_full");
    check("full_ready", 32'(rx_ready_o), 32'd0);
    check("full_irq", 32'(rx_irq_o), 32'd1);
    frame(10, 1'b0);
    frame(11, 1'b1);
    rd_const('h23, 32'h0000_020F, "status_drop2");
    rd_const('h20, 32'h0, "head_wrapped");
    wr('h10, 32'h0);
    check("release_ready", 32'(rx_ready_o), 32'd1);
    rd_const('h20, 32'h0, "release_head");
    wr('h23, 32'hF);
    rd_const('h23, 32'h0, "w1c_all");

    // CLR mid-ring
    frame(70, 1'b0);
    wr('h21, 32'h3);
    rd_const('h20, 32'h0, "clr_head");
    rd_const('h23, 32'h0, "clr_status");
    for (int i = 0; i < N; i++) rd_const('h10 + i, 32'h0, "clr_desc");
    rd_const('h03, 32'h300, "clr_saddr_kept");
    rd_const('h21, 32'h1, "clr_en_kept");
    rd_const('h22, 32'h2, "clr_irqen_kept");

    // Continuous release: 10 completions wrap the head to 2
    h = 0;
    for (int i = 0; i < 10; i++) begin
      frame(200 + i, 1'b0);
      wr('h10 + h, 32'h0);
      h = (h + 1) % N;
    end
    rd_const('h20, 32'h2, "wrap_head");
    check("wrap_saddr", 32'(rx_startaddr_o), 32'h200);

    // Frame completion racing software writes
    step(1'b1, 32, 1'b0, 1'b1, 'h23, 32'h1);
    rd_const('h23, 32'h1, "done_set_wins");
    step(1'b1, 40, 1'b0, 1'b1, 'h13, 32'h0);
    rd_const('h13, 32'h8000_0028, "own_hw_wins");
    rd('h20, "race_head");

    // CLR and frame in one cycle: frame discarded, no OVF
    step(1'b1, 50, 1'b0, 1'b1, 'h21, 32'h3);
    rd_const('h23, 32'h0, "clr_beats_frame");
    rd_const('h20, 32'h0, "clr_frame_head");
    rd_const('h10, 32'h0, "clr_frame_desc0");

    // DROP saturation, then clear racing a drop
    wr('h21, 32'h0);
    for (int i = 0; i < 258; i++) frame(1, 1'b0);
    rd_const('h23, 32'h0000_FF04, "drop_saturate");
    step(1'b1, 1, 1'b0, 1'b1, 'h23, 32'h4);
    rd_const('h23, 32'h0000_0104, "drop_clr_race");
    wr('h21, 32'h1);

    // Randomized phase
    for (int k = 0; k < 400; k++) begin
      sel = $urandom_range(0, 99);
      fd  = ($urandom_range(0, 2) == 0);
      wen = 1'b1;
      d   = $urandom;
      a   = 0;
      if (sel < 40) begin
        a = 'h10 + $urandom_range(0, 15);
        d[31] = ($urandom_range(0, 3) == 0);
      end else if (sel < 48) a = 'h23;
      else if (sel < 52) a = 'h22;
      else if (sel < 56) a = $urandom_range(0, 15);
      else if (sel < 60) begin
        a = 'h21;
        d[0] = ($urandom_range(0, 7) != 0);
        d[1] = ($urandom_range(0, 9) == 0);
      end else if (sel < 66) a = $urandom_range(0, 63);
      else wen = 1'b0;
      step(fd, $urandom_range(0, 65535), 1'($urandom_range(0, 1)), wen, a, d);
      chk_out("rand");
      if (k % 5 == 0) rd($urandom_range(0, 63), "rand_rd");
    end

    // Async reset in the middle of a burst
    wr('h21, 32'h3);
    wr('h22, 32'hF);
    for (int i = 0; i < 3; i++) begin
      frame(300 + i, 1'b0);
      wr('h10 + i, 32'h0);
    end
    chk_out("pre_rst");
    @(negedge clk_i);
    cfg_addr_i   = 6'h20;
    frame_done_i = 1'b1;
    frame_len_i  = 16'd99;
    #2;
    rstn_i = 1'b0;
    #1;
    check("arst_ready", 32'(rx_ready_o), 32'd0);
    check("arst_saddr", 32'(rx_startaddr_o), 32'd0);
    check("arst_irq",   32'(rx_irq_o), 32'd0);
    check("arst_rdata", cfg_data_o, 32'd0);
    frame_done_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    rstn_i = 1'b1;
    rd('h23, "post_rst_status");
    rd('h11, "post_rst_desc1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
